block_ram_dp: RTL

Parametrised true-dual-port block RAM, the successor to the fixed 16-bit dual-port RAM used for CPU/microcode storage. It generalises data width, depth and output pipelining, resolves cross-port hazards per byte lane, and has an optional post-reset clear sequencer. It sits between bus masters (CPU data path, DMA/VGA side) and on-chip memory. Both ports are synchronous to one clock.

---
 rtl/block_ram_dp.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/block_ram_dp.sv
// -----------------------------------------------------------------------------
// block_ram_dp
// True-dual-port block RAM. Both ports run on one clock. Each port has
// per-byte write enables. The read is write-first and post-cycle, so the
// returned word already contains the writes from both ports in the same
// cycle. An optional clear sequencer zeroes the array after reset.
//
// Ports
//   clk, reset_n           : clock, asynchronous active-low reset
//   busy                   : clear sequence running, port requests dropped
//   dbg_state              : clear sequencer state (0 = CLEAR, 1 = READY)
//   addr_x, rd_en_x,       : port x request (x = a, b); a write also reads
//   wr_en_x, be_x, wdata_x
//   q_x, q_valid_x         : read data (held between reads) and its strobe
//   collision              : same-address dual write with overlapping lanes
//
// Handshake: a port request is taken on a rising edge when busy=0 and
// (rd_en|wr_en)=1. There is no ready/backpressure. Exactly one q_valid
// pulse follows each taken request, after 1 cycle (OUTPUT_REG=0) or
// 2 cycles (OUTPUT_REG=1). Requests made while busy=1 are discarded.
// -----------------------------------------------------------------------------
module block_ram_dp #(
    parameter int WORDS          = 256,
    parameter int DATA_WIDTH     = 16,
    parameter int OUTPUT_REG     = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_BITS     = $clog2(WORDS),
    localparam int BYTES         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  busy,
    output logic                  dbg_state,
    input  logic [ADDR_BITS-1:0]  addr_a,
    input  logic                  rd_en_a,
    input  logic                  wr_en_a,
    input  logic [BYTES-1:0]      be_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [ADDR_BITS-1:0]  addr_b,
    input  logic                  rd_en_b,
    input  logic                  wr_en_b,
    input  logic [BYTES-1:0]      be_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  q_valid_a,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  q_valid_b,
    output logic                  collision
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WORDS - 1);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];

    clr_state_e           state_q;
    logic [ADDR_BITS-1:0] cnt_q;

    logic                  acc_a, acc_b, same_addr;
    logic [BYTES-1:0]      wa_a, wa_b;
    logic [DATA_WIDTH-1:0] rd_a_d, rd_b_d;
    logic                  coll_d;

    logic [DATA_WIDTH-1:0] q1_a_q, q1_b_q;
    logic                  v1_a_q, v1_b_q, c1_q;

    assign busy      = (state_q == CLEAR);
    assign dbg_state = state_q;

    // Clear sequencer: one word per cycle. The counter holds at the top
    // address on the way out, so it never wraps back into a second pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            if (cnt_q == LAST_ADDR) begin
                state_q <= READY;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // reset_n is included so nothing reaches the array while reset is held.
    assign acc_a     = reset_n && !busy && (rd_en_a || wr_en_a);
    assign acc_b     = reset_n && !busy && (rd_en_b || wr_en_b);
    assign wa_a      = {BYTES{acc_a && wr_en_a}} & be_a;
    assign wa_b      = {BYTES{acc_b && wr_en_b}} & be_b;
    assign same_addr = (addr_a == addr_b);
    assign coll_d    = same_addr && (|(wa_a & wa_b));

    // Array update. B lanes are written first and A lanes second, so on a
    // shared address A takes every lane both ports enable.
    always_ff @(posedge clk) begin
        if (reset_n && state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (wa_b[i]) mem_q[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
                if (wa_a[i]) mem_q[addr_a][8*i +: 8] <= wdata_a[8*i +: 8];
            end
        end
    end

    // Post-cycle read data, resolved per lane. Order is A write, then
    // B write, then stored lane, so both ports see the same word when
    // they share an address.
    always_comb begin
        rd_a_d = mem_q[addr_a];
        rd_b_d = mem_q[addr_b];
        for (int i = 0; i < BYTES; i++) begin
            if (wa_a[i]) begin
                rd_a_d[8*i +: 8] = wdata_a[8*i +: 8];
            end else if (wa_b[i] && same_addr) begin
                rd_a_d[8*i +: 8] = wdata_b[8*i +: 8];
            end
            if (wa_a[i] && same_addr) begin
                rd_b_d[8*i +: 8] = wdata_a[8*i +: 8];
            end else if (wa_b[i]) begin
                rd_b_d[8*i +: 8] = wdata_b[8*i +: 8];
            end
        end
    end

    // First read stage. q only loads on a taken request, so it keeps its
    // value between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q1_a_q <= '0;
            q1_b_q <= '0;
            v1_a_q <= 1'b0;
            v1_b_q <= 1'b0;
            c1_q   <= 1'b0;
        end else begin
            v1_a_q <= acc_a;
            v1_b_q <= acc_b;
            c1_q   <= coll_d;
            if (acc_a) q1_a_q <= rd_a_d;
            if (acc_b) q1_b_q <= rd_b_d;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] q2_a_q, q2_b_q;
            logic                  v2_a_q, v2_b_q, c2_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    q2_a_q <= '0;
                    q2_b_q <= '0;
                    v2_a_q <= 1'b0;
                    v2_b_q <= 1'b0;
                    c2_q   <= 1'b0;
                end else begin
                    v2_a_q <= v1_a_q;
                    v2_b_q <= v1_b_q;
                    c2_q   <= c1_q;
                    if (v1_a_q) q2_a_q <= q1_a_q;
                    if (v1_b_q) q2_b_q <= q1_b_q;
                end
            end

            assign q_a       = q2_a_q;
            assign q_b       = q2_b_q;
            assign q_valid_a = v2_a_q;
            assign q_valid_b = v2_b_q;
            assign collision = c2_q;
        end else begin : g_noreg
            assign q_a       = q1_a_q;
            assign q_b       = q1_b_q;
            assign q_valid_a = v1_a_q;
            assign q_valid_b = v1_b_q;
            assign collision = c1_q;
        end
    endgenerate

endmodule
